// File: rtl/tcpc_tx.sv
// USB-PD TCPC protocol-layer transmit engine: waits for an idle CC line, streams
// the TX buffer to the PHY, waits for GoodCRC with retries, and reports the outcome
// through the TCPCI ALERT bits (4 TransmitFailed, 5 TransmitDiscarded, 6 TransmitSuccessful).
module tcpc_tx #(
    parameter int unsigned CRC_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        Start,
    input  logic        iTX_REQ,
    input  logic [7:0]  iTRANSMIT,
    input  logic [7:0]  iTX_BYTE_COUNT,
    input  logic [7:0]  iTX_DATA,
    input  logic        iPHY_ACK,
    input  logic        CC_Busy,
    input  logic        GoodCRC_Received,
    input  logic        Rx_Message_Discard,
    input  logic [15:0] iALERT_CLEAR,
    output logic [7:0]  oDIR_READ,
    output logic [7:0]  oDATA_to_PHY,
    output logic        oDATA_VALID,
    output logic        oRESET_to_PHY,
    output logic        oTx_State_Machine_ACTIVE,
    output logic [15:0] oALERT
);

    localparam int unsigned ALERT_FAILED    = 4;
    localparam int unsigned ALERT_DISCARDED = 5;
    localparam int unsigned ALERT_SUCCESS   = 6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_RESET,
        S_WAIT_CC,
        S_SEND,
        S_WAIT_CRC,
        S_RETRY,
        S_SUCCESS,
        S_FAILED,
        S_DISCARDED
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        limit_q, limit_d;
    logic [1:0]        retry_q, retry_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [15:0]       alert_q, alert_d;
    logic              valid_q, rst_phy_q, active_q;
    logic              unused_transmit;

    // Frame-type bits 3 and 7:6 carry no meaning for the transmit engine.
    assign unused_transmit = ^{iTRANSMIT[7:6], iTRANSMIT[3]};

    // Next-state, counters and alert update.
    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        retry_d = retry_q;
        count_d = count_q;
        idx_d   = '0;
        timer_d = timer_q;
        alert_d = alert_q & ~iALERT_CLEAR;

        case (state_q)
            S_IDLE: begin
                retry_d = '0;
                timer_d = '0;
                if (iTX_REQ && Start) begin
                    limit_d = iTRANSMIT[5:4];
                    count_d = iTX_BYTE_COUNT;
                    if (iTRANSMIT[2:0] == 3'b101 || iTRANSMIT[2:0] == 3'b110) begin
                        state_d = S_SEND_RESET;
                    end else if (iTRANSMIT[2:0] == 3'b111 || iTX_BYTE_COUNT == 8'd0) begin
                        state_d = S_FAILED;
                    end else begin
                        state_d = S_WAIT_CC;
                    end
                end
            end
            S_SEND_RESET: state_d = S_SUCCESS;
            S_WAIT_CC: begin
                if (Rx_Message_Discard) begin
                    state_d = S_DISCARDED;
                end else if (!CC_Busy) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                idx_d = idx_q;
                if (Rx_Message_Discard) begin
                    state_d = S_DISCARDED;
                    idx_d   = '0;
                end else if (iPHY_ACK) begin
                    if (idx_q == count_q - 8'd1) begin
                        state_d = S_WAIT_CRC;
                        idx_d   = '0;
                        timer_d = '0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            S_WAIT_CRC: begin
                // A GoodCRC arriving on the timeout cycle still counts as success.
                if (GoodCRC_Received) begin
                    state_d = S_SUCCESS;
                end else if (timer_q == CNT_W'(CRC_TIMEOUT - 1)) begin
                    state_d = S_RETRY;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_RETRY: begin
                if (Rx_Message_Discard) begin
                    state_d = S_DISCARDED;
                end else if (retry_q < limit_q) begin
                    retry_d = retry_q + 2'd1;
                    state_d = S_WAIT_CC;
                end else begin
                    state_d = S_FAILED;
                end
            end
            S_SUCCESS, S_FAILED, S_DISCARDED: begin
                retry_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outcome bits are set on entry to the one-cycle result states; set beats clear.
        if (state_d == S_SUCCESS   && state_q != S_SUCCESS)   alert_d[ALERT_SUCCESS]   = 1'b1;
        if (state_d == S_FAILED    && state_q != S_FAILED)    alert_d[ALERT_FAILED]    = 1'b1;
        if (state_d == S_DISCARDED && state_q != S_DISCARDED) alert_d[ALERT_DISCARDED] = 1'b1;
        alert_d[15:7] = '0;
        alert_d[3:0]  = '0;
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= S_IDLE;
            limit_q   <= '0;
            retry_q   <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            alert_q   <= '0;
            valid_q   <= 1'b0;
            rst_phy_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            retry_q   <= retry_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            alert_q   <= alert_d;
            valid_q   <= (state_d == S_SEND);
            rst_phy_q <= (state_d == S_SEND_RESET);
            active_q  <= (state_d != S_IDLE);
        end
    end

    // Buffer read data flows straight to the PHY so byte and address stay aligned.
    assign oDATA_to_PHY             = valid_q ? iTX_DATA : 8'd0;
    assign oDIR_READ                = idx_q;
    assign oDATA_VALID              = valid_q;
    assign oRESET_to_PHY            = rst_phy_q;
    assign oTx_State_Machine_ACTIVE = active_q;
    assign oALERT                   = alert_q;

endmodule
